// File: rtl/scoreboard_reg_file.sv
// -----------------------------------------------------------------------------
// scoreboard_reg_file
//
// Register file with a per-register pending-write scoreboard for the in-order
// core. Decode reads two operands (with same-cycle writeback bypass) and asks
// to issue. The block answers with a single combinational stall. Issued
// destination writes are counted per register. Writebacks store data and
// retire one pending write, so back-to-back writes to one register issue
// freely until the counter is full.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   rd_addr0/1, rd_en0/1   decode source addresses and "source used" flags
//   rd_data0/1             operand data (combinational, writeback bypassed)
//   issue_valid/we/dst     decode instruction, writes-destination, destination
//   issue_stall            hold decode this cycle (combinational)
//   wb_we/addr/data        writeback port
//   flush                  clear every pending counter (data writes still land)
//   busy                   per-register "pending != 0" from registered state
//   dbg_addr, dbg_data     raw register contents, no bypass
// -----------------------------------------------------------------------------
module scoreboard_reg_file #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2,
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = 0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [ADDR_W-1:0]   rd_addr0,
   input  logic [ADDR_W-1:0]   rd_addr1,
   input  logic                rd_en0,
   input  logic                rd_en1,
   output logic [DATA_W-1:0]   rd_data0,
   output logic [DATA_W-1:0]   rd_data1,
   input  logic                issue_valid,
   input  logic                issue_we,
   input  logic [ADDR_W-1:0]   issue_dst,
   output logic                issue_stall,
   input  logic                wb_we,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy,
   input  logic [ADDR_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);

   // Every per-register view is padded to the full address space so that any
   // address indexes a defined bit; unimplemented slots read as zero.
   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0]             w_real;   // slot is a writable register
   logic [DEPTH-1:0]             w_hz;     // slot would cause a RAW hazard now
   logic [DEPTH-1:0]             w_full;   // slot pending counter at maximum
   logic [DEPTH-1:0][DATA_W-1:0] w_reg_q;
   logic                         w_stall;
   logic                         w_fire;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         if ((gi < NUM_REGS) && !((ZERO_REG != 0) && (gi == 0))) begin : g_reg
            logic [DATA_W-1:0] r_data;
            logic [CNT_W-1:0]  r_pend;
            logic              w_wb_hit;
            logic              w_inc;
            logic              w_dec;

            assign w_wb_hit = wb_we && (wb_addr == ADDR_W'(gi));
            assign w_inc    = w_fire && issue_we && (issue_dst == ADDR_W'(gi));
            // A writeback to a non-pending register stores data but must not
            // underflow the counter.
            assign w_dec    = w_wb_hit && (r_pend != '0);

            always_ff @(posedge clk or negedge resetn) begin
               if (!resetn) begin
                  r_data <= '0;
                  r_pend <= '0;
               end else begin
                  if (w_wb_hit) begin
                     r_data <= wb_data;
                  end
                  if (flush) begin
                     r_pend <= '0;
                  end else if (w_inc && !w_dec) begin
                     r_pend <= r_pend + CNT_W'(1);
                  end else if (w_dec && !w_inc) begin
                     r_pend <= r_pend - CNT_W'(1);
                  end
               end
            end

            assign w_real[gi]  = 1'b1;
            assign w_reg_q[gi] = r_data;
            assign w_full[gi]  = (r_pend == '1);
            // The last outstanding write arriving this cycle is forwarded by
            // the bypass, so it no longer blocks a reader.
            assign w_hz[gi]    = (r_pend != '0) &&
                                 !((r_pend == CNT_W'(1)) && w_wb_hit);
            assign busy[gi]    = (r_pend != '0);
         end else begin : g_none
            assign w_real[gi]  = 1'b0;
            assign w_reg_q[gi] = '0;
            assign w_full[gi]  = 1'b0;
            assign w_hz[gi]    = 1'b0;
            if (gi < NUM_REGS) begin : g_zero_busy
               assign busy[gi] = 1'b0;
            end
         end
      end
   endgenerate

   // Stall depends only on decode/writeback inputs and counter state; the
   // WAW check deliberately ignores a same-cycle writeback.
   assign w_stall = issue_valid &&
                    ((rd_en0 && w_hz[rd_addr0]) ||
                     (rd_en1 && w_hz[rd_addr1]) ||
                     (issue_we && w_full[issue_dst]));
   assign w_fire      = issue_valid && !w_stall;
   assign issue_stall = w_stall;

   assign rd_data0 = !w_real[rd_addr0] ? '0 :
                     (wb_we && (wb_addr == rd_addr0)) ? wb_data : w_reg_q[rd_addr0];
   assign rd_data1 = !w_real[rd_addr1] ? '0 :
                     (wb_we && (wb_addr == rd_addr1)) ? wb_data : w_reg_q[rd_addr1];

   assign dbg_data = w_reg_q[dbg_addr];

endmodule
